idli_sync_m: RTL and testbench
==============================

IDLI_SYNC_M -- requirements
Module: idli_sync_m

Interface
REQ-001 Parameter SLICES, default 4, meaning slices per 16-bit word; SHALL be a power of two and >= 2.
REQ-002 Parameter FLUSH_WORDS, default 2, meaning words discarded after a redirect before execution may resume; legal range 0..15.
REQ-003 Parameter CNT_W, default 16, meaning width of the executed-word counter.
REQ-004 Derived localparam CTR_W = clog2(SLICES).
REQ-005 i_sync_gck  input  1  clock; the only clock.
REQ-006 i_sync_rst  input  1  reset, asynchronous, active-high.
REQ-007 i_sync_redirect  input  1  redirect request; may pulse in any cycle.
REQ-008 i_sync_stall_req  input  1  pipeline stall request; sampled on the last slice only.
REQ-009 i_sync_instr_vld  input  1  SQI instruction valid; sampled on the last slice only.
REQ-010 o_sync_ctr  output  CTR_W  slice counter.
REQ-011 o_sync_first  output  1  high when o_sync_ctr == 0.
REQ-012 o_sync_last  output  1  high when o_sync_ctr == SLICES-1.
REQ-013 o_sync_exec_en  output  1  current word executes.
REQ-014 o_sync_hold  output  1  SQI holds its current instruction.
REQ-015 o_sync_sqi_redirect  output  1  one-cycle redirect pulse to SQI.
REQ-016 o_sync_state  output  2  state encoding: FLUSH=0, RUN=1, STALL=2.
REQ-017 o_sync_exec_cnt  output  CNT_W  saturating count of executed words.

Function
REQ-018 The slice counter SHALL increment by 1 every cycle and wrap from SLICES-1 to 0; stall, redirect and starvation SHALL NOT affect it.
REQ-019 The boundary cycle is the cycle with o_sync_last=1; all state, flush-count and exec-count updates SHALL occur only at the end of a boundary cycle, so each takes effect from the next ctr==0.
REQ-020 A redirect-pending flag SHALL set on any cycle with i_sync_redirect=1 and clear at the end of the boundary cycle; "redirect taken" = pending flag or i_sync_redirect high during the boundary cycle.
REQ-021 Boundary priority SHALL be redirect > stall > starvation.
REQ-022 Any state, redirect taken: next state FLUSH; flush count loads FLUSH_WORDS; o_sync_sqi_redirect high for exactly the following ctr==0 cycle.
REQ-023 FLUSH, no redirect: if flush count != 0, decrement it and stay; else if i_sync_instr_vld, go to RUN; else stay.
REQ-024 RUN, no redirect: if i_sync_stall_req, go to STALL; else if !i_sync_instr_vld, go to FLUSH with flush count 0 and no o_sync_sqi_redirect pulse; else stay.
REQ-025 STALL, no redirect: if !i_sync_stall_req, go to RUN; else stay.
REQ-026 o_sync_exec_en SHALL be (state==RUN), and o_sync_hold SHALL be (state==STALL); both are constant across a whole word.
REQ-027 o_sync_exec_cnt SHALL increment at each boundary where state==RUN, including a word ending in redirect, and SHALL saturate at 2^CNT_W-1.
REQ-028 A redirect during FLUSH SHALL restart the flush, reloading the count and re-pulsing o_sync_sqi_redirect.
REQ-029 A redirect arriving after a boundary SHALL be held pending to the next boundary and SHALL never be lost.

Reset
REQ-030 While i_sync_rst=1, outputs SHALL immediately take: ctr=0, first=1, last=0, exec_en=0, hold=0, sqi_redirect=0, state=FLUSH, exec_cnt=0; internal flush count=FLUSH_WORDS and pending flag=0.
REQ-031 Reset asserted mid-word SHALL abandon the word, discard pending redirect and stall, and count resumes at 0 on the first clock edge after release.

Verification
REQ-032 Defaults, instr_vld=1 from reset release (cycle 0) -> ctr 0,1,2,3,0,...; exec_en=1 from cycle 12; exec_cnt=1 at cycle 16.
REQ-033 RUN, redirect pulse at ctr==1 -> sqi_redirect=1 only at next ctr==0; exec_en=0 for 3 words; exec_cnt +1 for the redirected word.
REQ-034 RUN, stall_req=1 and redirect=1 at the same boundary -> state FLUSH, hold=0, sqi_redirect pulse.
REQ-035 RUN, stall_req=1 at one boundary then 0 at the next -> hold=1 and exec_en=0 for exactly 1 word, then RUN; exec_cnt unchanged for that word.
REQ-036 RUN, instr_vld=0 at one boundary then 1 at the next -> one FLUSH word, no sqi_redirect pulse, then RUN.
REQ-037 CNT_W=4, 20 RUN words -> exec_cnt holds 15; async reset asserted at ctr==2 -> all REQ-030 values in the same cycle.

Source files
------------

// File: rtl/idli_sync_m_if.sv
// Sequencer handshake bundle: pipeline requests in, slice timing and
// execution controls out.
interface idli_sync_m_if #(
   parameter int unsigned CTR_W = 2,
   parameter int unsigned CNT_W = 16
);
   logic             i_sync_redirect;
   logic             i_sync_stall_req;
   logic             i_sync_instr_vld;
   logic [CTR_W-1:0] o_sync_ctr;
   logic             o_sync_first;
   logic             o_sync_last;
   logic             o_sync_exec_en;
   logic             o_sync_hold;
   logic             o_sync_sqi_redirect;
   logic [1:0]       o_sync_state;
   logic [CNT_W-1:0] o_sync_exec_cnt;

   modport master (
      output i_sync_redirect, i_sync_stall_req, i_sync_instr_vld,
      input  o_sync_ctr, o_sync_first, o_sync_last, o_sync_exec_en,
             o_sync_hold, o_sync_sqi_redirect, o_sync_state, o_sync_exec_cnt
   );

   modport slave (
      input  i_sync_redirect, i_sync_stall_req, i_sync_instr_vld,
      output o_sync_ctr, o_sync_first, o_sync_last, o_sync_exec_en,
             o_sync_hold, o_sync_sqi_redirect, o_sync_state, o_sync_exec_cnt
   );
endinterface

// File: rtl/idli_sync_m.sv
// Bit-serial word sequencer: free-running slice counter plus a word-level
// FLUSH/RUN/STALL controller that only changes state on the last slice.
module idli_sync_m #(
   parameter int unsigned SLICES      = 4,
   parameter int unsigned FLUSH_WORDS = 2,
   parameter int unsigned CNT_W       = 16
) (
   input  logic         i_sync_gck,
   input  logic         i_sync_rst,
   idli_sync_m_if.slave bus
);
   localparam int unsigned CTR_W = $clog2(SLICES);
   localparam int unsigned FLS_W = 4;

   typedef enum logic [1:0] {
      ST_FLUSH = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2
   } state_t;

   state_t           state_q;
   logic [CTR_W-1:0] ctr_q;
   logic             first_q;
   logic             last_q;
   logic [FLS_W-1:0] flush_q;
   logic             pend_q;
   logic             exec_en_q;
   logic             hold_q;
   logic             sqi_redir_q;
   logic [CNT_W-1:0] exec_cnt_q;
   logic             redir_taken_c;

   // A redirect seen earlier in the word, or on the boundary itself, wins.
   assign redir_taken_c = pend_q | bus.i_sync_redirect;

   always_ff @(posedge i_sync_gck or posedge i_sync_rst) begin
      if (i_sync_rst) begin
         state_q     <= ST_FLUSH;
         ctr_q       <= '0;
         first_q     <= 1'b1;
         last_q      <= 1'b0;
         flush_q     <= FLS_W'(FLUSH_WORDS);
         pend_q      <= 1'b0;
         exec_en_q   <= 1'b0;
         hold_q      <= 1'b0;
         sqi_redir_q <= 1'b0;
         exec_cnt_q  <= '0;
      end else begin
         ctr_q       <= ctr_q + CTR_W'(1);
         first_q     <= (ctr_q == CTR_W'(SLICES - 1));
         last_q      <= (ctr_q == CTR_W'(SLICES - 2));
         sqi_redir_q <= 1'b0;

         if (!last_q) begin
            pend_q <= pend_q | bus.i_sync_redirect;
         end else begin
            pend_q <= 1'b0;
            if (state_q == ST_RUN && exec_cnt_q != '1)
               exec_cnt_q <= exec_cnt_q + CNT_W'(1);

            if (redir_taken_c) begin
               state_q     <= ST_FLUSH;
               flush_q     <= FLS_W'(FLUSH_WORDS);
               sqi_redir_q <= 1'b1;
               exec_en_q   <= 1'b0;
               hold_q      <= 1'b0;
            end else begin
               unique case (state_q)
                  ST_FLUSH: begin
                     if (flush_q != '0) begin
                        flush_q <= flush_q - FLS_W'(1);
                     end else if (bus.i_sync_instr_vld) begin
                        state_q   <= ST_RUN;
                        exec_en_q <= 1'b1;
                     end
                  end
                  ST_RUN: begin
                     if (bus.i_sync_stall_req) begin
                        state_q   <= ST_STALL;
                        exec_en_q <= 1'b0;
                        hold_q    <= 1'b1;
                     end else if (!bus.i_sync_instr_vld) begin
                        // Starvation: re-enter FLUSH without a flush window.
                        state_q   <= ST_FLUSH;
                        flush_q   <= '0;
                        exec_en_q <= 1'b0;
                     end
                  end
                  ST_STALL: begin
                     if (!bus.i_sync_stall_req) begin
                        state_q   <= ST_RUN;
                        exec_en_q <= 1'b1;
                        hold_q    <= 1'b0;
                     end
                  end
                  default: begin
                     state_q   <= ST_FLUSH;
                     exec_en_q <= 1'b0;
                     hold_q    <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

   assign bus.o_sync_ctr          = ctr_q;
   assign bus.o_sync_first        = first_q;
   assign bus.o_sync_last         = last_q;
   assign bus.o_sync_exec_en      = exec_en_q;
   assign bus.o_sync_hold         = hold_q;
   assign bus.o_sync_sqi_redirect = sqi_redir_q;
   assign bus.o_sync_state        = state_q;
   assign bus.o_sync_exec_cnt     = exec_cnt_q;
endmodule

// File: tb/tb_idli_sync_m.sv
// Self-checking bench for idli_sync_m: word-level reference model, directed
// scenarios, then randomized requests; a CNT_W=4 copy checks saturation.
module tb_idli_sync_m;
   localparam int SLICES = 4;
   localparam int FLUSH_WORDS = 2;
   localparam int M_FLUSH = 0, M_RUN = 1, M_STALL = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   idli_sync_m_if #(.CTR_W(2), .CNT_W(16)) bus16 ();
   idli_sync_m_if #(.CTR_W(2), .CNT_W(4))  bus4 ();

   idli_sync_m dut (.i_sync_gck(clk), .i_sync_rst(rst), .bus(bus16));
   idli_sync_m #(.CNT_W(4)) dut4 (.i_sync_gck(clk), .i_sync_rst(rst), .bus(bus4));

   int checks = 0;
   int failures = 0;
   int cyc_n = 0;

   // Reference model: values expected in the current cycle.
   int  m_ctr, m_state, m_flush, m_cnt;
   bit  m_pend, m_sqi;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h cycle=%0d t=%0t", tag, got, exp, cyc_n, $time);
      end
   endtask

   function automatic void model_reset();
      m_ctr = 0; m_state = M_FLUSH; m_flush = FLUSH_WORDS;
      m_cnt = 0; m_pend = 0; m_sqi = 0;
   endfunction

   function automatic void model_step(input bit r, input bit s, input bit v);
      if (m_ctr == SLICES - 1) begin
         bit taken = m_pend || r;
         m_pend = 0;
         m_sqi  = taken;
         if (m_state == M_RUN) m_cnt++;
         if (taken) begin
            m_state = M_FLUSH;
            m_flush = FLUSH_WORDS;
         end else if (m_state == M_FLUSH) begin
            if (m_flush > 0) m_flush--;
            else if (v) m_state = M_RUN;
         end else if (m_state == M_RUN) begin
            if (s) m_state = M_STALL;
            else if (!v) begin m_state = M_FLUSH; m_flush = 0; end
         end else if (!s) begin
            m_state = M_RUN;
         end
      end else begin
         m_pend = m_pend || r;
         m_sqi  = 0;
      end
      m_ctr = (m_ctr + 1) % SLICES;
   endfunction

   task automatic check_all();
      int c16 = (m_cnt > 65535) ? 65535 : m_cnt;
      int c4  = (m_cnt > 15) ? 15 : m_cnt;
      chk("ctr",      32'(bus16.o_sync_ctr),          32'(m_ctr));
      chk("first",    32'(bus16.o_sync_first),        32'(m_ctr == 0));
      chk("last",     32'(bus16.o_sync_last),         32'(m_ctr == SLICES - 1));
      chk("exec_en",  32'(bus16.o_sync_exec_en),      32'(m_state == M_RUN));
      chk("hold",     32'(bus16.o_sync_hold),         32'(m_state == M_STALL));
      chk("sqi_redir",32'(bus16.o_sync_sqi_redirect), 32'(m_sqi));
      chk("state",    32'(bus16.o_sync_state),        32'(m_state));
      chk("cnt16",    32'(bus16.o_sync_exec_cnt),     32'(c16));
      chk("cnt4",     32'(bus4.o_sync_exec_cnt),      32'(c4));
      chk("state4",   32'(bus4.o_sync_state),         32'(m_state));
   endtask

   // One clock cycle: check outputs, drive inputs, advance the model.
   task automatic cyc(input bit r, input bit s, input bit v);
      check_all();
      bus16.i_sync_redirect = r; bus16.i_sync_stall_req = s; bus16.i_sync_instr_vld = v;
      bus4.i_sync_redirect  = r; bus4.i_sync_stall_req  = s; bus4.i_sync_instr_vld  = v;
      model_step(r, s, v);
      @(posedge clk);
      @(negedge clk);
      cyc_n++;
   endtask

   task automatic to_ctr(input int c, input bit s, input bit v);
      for (int i = 0; i < SLICES && m_ctr != c; i++) cyc(0, s, v);
      chk("align_ctr", 32'(m_ctr), 32'(c));
   endtask

   task automatic to_run();
      for (int i = 0; i < 64 && m_state != M_RUN; i++) cyc(0, 0, 1);
      chk("reach_run", 32'(m_state), 32'(M_RUN));
   endtask

   task automatic async_reset_check();
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_ctr",   32'(bus16.o_sync_ctr), 32'd0);
      chk("rst_first", 32'(bus16.o_sync_first), 32'd1);
      chk("rst_last",  32'(bus16.o_sync_last), 32'd0);
      chk("rst_exec",  32'(bus16.o_sync_exec_en), 32'd0);
      chk("rst_hold",  32'(bus16.o_sync_hold), 32'd0);
      chk("rst_sqi",   32'(bus16.o_sync_sqi_redirect), 32'd0);
      chk("rst_state", 32'(bus16.o_sync_state), 32'd0);
      chk("rst_cnt",   32'(bus16.o_sync_exec_cnt), 32'd0);
      chk("rst_cnt4",  32'(bus4.o_sync_exec_cnt), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check_all();
      rst = 1'b0;
      cyc_n = 0;
   endtask

   initial begin
      bus16.i_sync_redirect = 0; bus16.i_sync_stall_req = 0; bus16.i_sync_instr_vld = 0;
      bus4.i_sync_redirect  = 0; bus4.i_sync_stall_req  = 0; bus4.i_sync_instr_vld  = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst = 1'b0;
      cyc_n = 0;

      // Cold start with a steady instruction stream; 30 words saturates CNT_W=4.
      for (int i = 0; i < 120; i++) begin
         if (cyc_n == 12) chk("exec_en_c12", 32'(bus16.o_sync_exec_en), 32'd1);
         if (cyc_n == 11) chk("exec_en_c11", 32'(bus16.o_sync_exec_en), 32'd0);
         if (cyc_n == 16) chk("cnt_c16", 32'(bus16.o_sync_exec_cnt), 32'd1);
         cyc(0, 0, 1);
      end
      chk("cnt4_sat", 32'(bus4.o_sync_exec_cnt), 32'd15);

      // Redirect mid-word while running.
      to_run(); to_ctr(1, 0, 1); cyc(1, 0, 1);
      repeat (16) cyc(0, 0, 1);

      // Stall and redirect on the same boundary.
      to_run(); to_ctr(3, 0, 1); cyc(1, 1, 1);
      repeat (8) cyc(0, 0, 1);

      // One-word stall.
      to_run(); to_ctr(3, 0, 1); cyc(0, 1, 1);
      to_ctr(3, 0, 1); cyc(0, 0, 1);
      repeat (8) cyc(0, 0, 1);

      // One-word starvation.
      to_run(); to_ctr(3, 0, 1); cyc(0, 0, 0);
      to_ctr(3, 0, 1); cyc(0, 0, 1);
      repeat (8) cyc(0, 0, 1);

      // Redirect during flush restarts it; redirect at ctr 0 stays pending.
      to_run(); to_ctr(2, 0, 1); cyc(1, 0, 1);
      to_ctr(1, 0, 1); cyc(1, 0, 1);
      to_ctr(0, 0, 1); cyc(1, 0, 1);
      repeat (24) cyc(0, 0, 1);

      // Asynchronous reset mid-word with a pending redirect and stall.
      to_run(); to_ctr(1, 1, 1); cyc(1, 1, 1);
      async_reset_check();

      for (int i = 0; i < 1500; i++)
         cyc($urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0);

      to_ctr(2, 0, 1);
      async_reset_check();
      repeat (20) cyc(0, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
